// File: rtl/frame_pixel_writer.sv
// rtl/frame_pixel_writer.sv - RGB pixel stream to packed frame-memory word writer
//
// Takes one RGB pixel per handshake and writes it as one V-bit word at
// BASE_ADDR + 3*(y*IMG_W + x). This is the layout the VGA scan-out reads.
// In each 32-bit lane, the channel byte sits in the low 8 bits.
//
// Ports
//   i_clk, i_rst         clock; asynchronous active-low reset
//   i_start              begin a frame (only looked at while idle)
//   i_pix_valid/o_pix_ready, i_pix_r/g/b   pixel stream handshake and data
//   o_mem_req/i_mem_gnt  arbitrated write request / grant
//   o_mem_we             write strobe, o_mem_req & i_mem_gnt
//   o_mem_address/o_mem_wd  write address and data, held while requesting
//   o_busy, o_done       frame in progress / one-cycle end-of-frame pulse
module frame_pixel_writer #(
  parameter int             S         = 32,
  parameter int             V         = 192,
  parameter int             IMG_W     = 100,
  parameter int             IMG_H     = 100,
  parameter logic [S-1:0]   BASE_ADDR = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_pix_valid,
  output logic          o_pix_ready,
  input  logic [7:0]    i_pix_r,
  input  logic [7:0]    i_pix_g,
  input  logic [7:0]    i_pix_b,
  output logic          o_mem_req,
  input  logic          i_mem_gnt,
  output logic          o_mem_we,
  output logic [S-1:0]  o_mem_address,
  output logic [V-1:0]  o_mem_wd,
  output logic          o_busy,
  output logic          o_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, LOAD, REQ, DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [S-1:0]   r_addr;
  logic [V-1:0]   r_wd;
  logic [V-1:0]   w_pix_word;
  logic           w_last;
  logic           w_fire;

  assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_fire = (r_state == REQ) && i_mem_gnt;

  // Only lanes 0..2 carry data. Every other bit stays zero.
  always_comb begin
    w_pix_word             = '0;
    w_pix_word[7:0]        = i_pix_r;
    w_pix_word[S+7:S]      = i_pix_g;
    w_pix_word[2*S+7:2*S]  = i_pix_b;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start)     w_next = LOAD;
      LOAD:    if (i_pix_valid) w_next = REQ;
      REQ:     if (i_mem_gnt)   w_next = w_last ? DONE : LOAD;
      DONE:                     w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  always_comb begin
    o_pix_ready = 1'b0;
    o_mem_req   = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: ;
      LOAD: begin
        o_pix_ready = 1'b1;
        o_busy      = 1'b1;
      end
      REQ: begin
        o_mem_req = 1'b1;
        o_busy    = 1'b1;
      end
      DONE: begin
        o_done = 1'b1;
        o_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // The address steps by 3 for every pixel, across row ends as well,
  // because rows are stored back to back.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= BASE_ADDR;
      r_wd   <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= BASE_ADDR;
      end
      if (r_state == LOAD && i_pix_valid) begin
        r_wd <= w_pix_word;
      end
      if (w_fire && !w_last) begin
        r_addr <= r_addr + S'(3);
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

  assign o_mem_we      = o_mem_req & i_mem_gnt;
  assign o_mem_address = r_addr;
  assign o_mem_wd      = r_wd;

endmodule
